ghost_path_engine: RTL and testbench

- Parametrised successor to the fixed three-ghost updater. Advances NUM_GHOSTS path pointers and reads each ghost's coordinate from one shared, time-multiplexed path ROM.
- Checks every ghost against the player for same-tile and swap (crossing) collisions.
- Slots into the game-logic step sequencer behind a start/finished handshake. Adds a freeze mode, a per-ghost enable mask and a sticky game-over flag.

---
 rtl/game_pkg.sv | 25 ++
 rtl/ghost_hit_check.sv | 27 ++
 rtl/ghost_path_engine.sv | 156 +++++++++++++++
 tb/tb_ghost_path_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-logic types, grid constants and FSM encodings
package game_pkg;

  typedef enum logic [2:0] {
    DIR_STILL = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  localparam int COLUMNS = 29;
  localparam int X_W     = 5;
  localparam int Y_W     = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADV   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // x sits at the top of a rom word; y follows directly below x; the rest is spare
  localparam int ROM_X_OFS = 0;

endpackage

// File: rtl/ghost_hit_check.sv
// rtl/ghost_hit_check.sv - same-tile and swap collision test for one mover
module ghost_hit_check #(
  parameter int X_W = game_pkg::X_W,
  parameter int Y_W = game_pkg::Y_W
) (
  input  logic [X_W-1:0] old_x,
  input  logic [Y_W-1:0] old_y,
  input  logic [X_W-1:0] new_x,
  input  logic [Y_W-1:0] new_y,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic [X_W-1:0] prev_x,
  input  logic [Y_W-1:0] prev_y,
  input  logic           first_step,
  output logic           hit
);

  logic same_tile;
  logic swapped;

  assign same_tile = (new_x == player_x) && (new_y == player_y);
  // ghost and player exchanged tiles during the same step
  assign swapped   = !first_step && (new_x == prev_x) && (new_y == prev_y) &&
                     (old_x == player_x) && (old_y == player_y);
  assign hit       = same_tile || swapped;

endmodule

// File: rtl/ghost_path_engine.sv
// rtl/ghost_path_engine.sv - advances ghost path pointers and checks player collisions
module ghost_path_engine #(
  parameter int NUM_GHOSTS = 3,
  parameter int X_W        = game_pkg::X_W,
  parameter int Y_W        = game_pkg::Y_W,
  parameter int IDX_W      = 7,
  parameter int ROM_AW     = 9,
  parameter int ROM_DW     = 11,
  parameter logic [NUM_GHOSTS*ROM_AW-1:0] PATH_BASE = {9'd142, 9'd63, 9'd0},
  parameter logic [NUM_GHOSTS*IDX_W-1:0]  PATH_LAST = {7'd50, 7'd78, 7'd63}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      freeze,
  input  logic [NUM_GHOSTS-1:0]     ghost_en,
  input  logic [X_W-1:0]            player_x,
  input  logic [Y_W-1:0]            player_y,
  input  logic                      clear_over,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [ROM_DW-1:0]         rom_q,
  output logic                      busy,
  output logic                      finished,
  output logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  output logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  output logic [NUM_GHOSTS-1:0]     hit_mask,
  output logic                      game_over
);

  import game_pkg::*;

  localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

  logic [2:0]            state;
  logic [GW-1:0]         g;
  logic [IDX_W-1:0]      idx [NUM_GHOSTS];
  logic                  lat_freeze;
  logic [NUM_GHOSTS-1:0] lat_en;
  logic [X_W-1:0]        lat_px, prev_x;
  logic [Y_W-1:0]        lat_py, prev_y;
  logic                  first_step;

  logic [GW-1:0]         first_g, next_g;
  logic                  any_en, has_next;
  logic [X_W-1:0]        new_x, old_x;
  logic [Y_W-1:0]        new_y, old_y;
  logic                  hit;

  // descending scan so the last match wins, giving the lowest qualifying ghost
  always_comb begin
    first_g  = '0;
    next_g   = '0;
    any_en   = 1'b0;
    has_next = 1'b0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (lat_en[i]) begin
        first_g = GW'(i);
        any_en  = 1'b1;
      end
      if (lat_en[i] && (i > int'(g))) begin
        next_g   = GW'(i);
        has_next = 1'b1;
      end
    end
  end

  assign rom_addr = (state == ST_FETCH) ?
                    PATH_BASE[int'(g)*ROM_AW +: ROM_AW] + ROM_AW'(idx[g]) : '0;

  assign new_x = rom_q[ROM_DW-1-ROM_X_OFS -: X_W];
  assign new_y = rom_q[ROM_DW-1-ROM_X_OFS-X_W -: Y_W];
  assign old_x = ghost_x[int'(g)*X_W +: X_W];
  assign old_y = ghost_y[int'(g)*Y_W +: Y_W];

  generate
    if (ROM_DW > X_W + Y_W) begin : g_spare
      logic spare_unused;
      assign spare_unused = ^rom_q[ROM_DW-X_W-Y_W-1:0];
    end
  endgenerate

  ghost_hit_check #(.X_W(X_W), .Y_W(Y_W)) u_hit (
    .old_x      (old_x),
    .old_y      (old_y),
    .new_x      (new_x),
    .new_y      (new_y),
    .player_x   (lat_px),
    .player_y   (lat_py),
    .prev_x     (prev_x),
    .prev_y     (prev_y),
    .first_step (first_step),
    .hit        (hit)
  );

  assign busy     = (state != ST_IDLE);
  assign finished = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      g          <= '0;
      for (int i = 0; i < NUM_GHOSTS; i++) idx[i] <= '0;
      ghost_x    <= '0;
      ghost_y    <= '0;
      hit_mask   <= '0;
      game_over  <= 1'b0;
      lat_freeze <= 1'b0;
      lat_en     <= '0;
      lat_px     <= '0;
      lat_py     <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      first_step <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          lat_freeze <= freeze;
          lat_en     <= ghost_en;
          lat_px     <= player_x;
          lat_py     <= player_y;
          hit_mask   <= '0;
          state      <= ST_ADV;
        end
        ST_ADV: begin
          if (!lat_freeze) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
              if (lat_en[i])
                idx[i] <= (idx[i] == PATH_LAST[i*IDX_W +: IDX_W]) ? '0 : idx[i] + 1'b1;
            end
          end
          g     <= first_g;
          state <= any_en ? ST_FETCH : ST_DONE;
        end
        ST_FETCH: state <= ST_CAPT;
        ST_CAPT: begin
          ghost_x[int'(g)*X_W +: X_W] <= new_x;
          ghost_y[int'(g)*Y_W +: Y_W] <= new_y;
          if (hit) hit_mask[g] <= 1'b1;
          g     <= next_g;
          state <= has_next ? ST_FETCH : ST_DONE;
        end
        ST_DONE: begin
          prev_x     <= lat_px;
          prev_y     <= lat_py;
          first_step <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if ((state == ST_DONE) && (|hit_mask)) game_over <= 1'b1;
      else if (clear_over) game_over <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ghost_path_engine.sv
// tb/tb_ghost_path_engine.sv - randomized bench for ghost_path_engine against a step-level model
module tb_ghost_path_engine;

  localparam int BASE [3] = '{0, 63, 142};
  localparam int LAST [3] = '{63, 78, 50};

  logic        clock = 1'b0;
  logic        reset, start, freeze, clear_over;
  logic [2:0]  ghost_en;
  logic [4:0]  player_x;
  logic [3:0]  player_y;
  logic [8:0]  rom_addr;
  logic [10:0] rom_q;
  logic        busy, finished, game_over;
  logic [14:0] ghost_x;
  logic [11:0] ghost_y;
  logic [2:0]  hit_mask;

  ghost_path_engine dut (
    .clock(clock), .reset(reset), .start(start), .freeze(freeze),
    .ghost_en(ghost_en), .player_x(player_x), .player_y(player_y),
    .clear_over(clear_over), .rom_addr(rom_addr), .rom_q(rom_q),
    .busy(busy), .finished(finished), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .hit_mask(hit_mask), .game_over(game_over)
  );

  always #5 clock = ~clock;

  logic [10:0] rom [512];
  always @(posedge clock) rom_q <= rom[rom_addr];

  int n_pass = 0;
  int n_total = 0;

  int       m_idx [3];
  int       m_x [3];
  int       m_y [3];
  bit       m_go, m_first;
  int       m_px, m_py;
  logic [2:0] m_hit;
  int       exp_addr [$];
  int       obs_addr [$];
  int       obs_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [10:0] word(input int x, input int y);
    logic [4:0] xs;
    logic [3:0] ys;
    xs = x[4:0];
    ys = y[3:0];
    return {xs, ys, 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_go = 0; m_first = 1; m_hit = '0; m_px = 0; m_py = 0;
  endtask

  task automatic check_state(input string tag);
    logic [14:0] ex;
    logic [11:0] ey;
    for (int i = 0; i < 3; i++) begin
      ex[i*5 +: 5] = 5'(m_x[i]);
      ey[i*4 +: 4] = 4'(m_y[i]);
    end
    chk({tag, "_ghost_x"}, 32'(ghost_x), 32'(ex));
    chk({tag, "_ghost_y"}, 32'(ghost_y), 32'(ey));
    chk({tag, "_hit_mask"}, 32'(hit_mask), 32'(m_hit));
    chk({tag, "_game_over"}, 32'(game_over), 32'(m_go));
  endtask

  // one game step: model predicts the whole step, then every cycle is compared
  task automatic step(input bit fr, input logic [2:0] en, input int px, input int py,
                      input bit co, input int extra);
    int e, lat, n, fcount, a, nx, ny;
    exp_addr.delete();
    obs_addr.delete();
    m_hit = '0;
    e = 0;
    for (int i = 0; i < 3; i++)
      if (en[i] && !fr) m_idx[i] = (m_idx[i] == LAST[i]) ? 0 : m_idx[i] + 1;
    for (int i = 0; i < 3; i++) begin
      if (en[i]) begin
        a  = (BASE[i] + m_idx[i]) % 512;
        exp_addr.push_back(a);
        nx = int'(rom[a][10:6]);
        ny = int'(rom[a][5:2]);
        if ((nx == px && ny == py) ||
            (!m_first && nx == m_px && ny == m_py && m_x[i] == px && m_y[i] == py))
          m_hit[i] = 1'b1;
        m_x[i] = nx;
        m_y[i] = ny;
        e++;
      end
    end
    lat = 2 + 2 * e;
    m_go = co ? (|m_hit) : (m_go || (|m_hit));
    m_px = px; m_py = py; m_first = 0;

    @(negedge clock);
    start = 1'b1; freeze = fr; ghost_en = en;
    player_x = 5'(px); player_y = 4'(py); clear_over = co;
    n = 0; fcount = 0; obs_lat = -1;
    while (n < lat + 2) begin
      @(posedge clock);
      #1;
      n++;
      start = (extra > 0 && n == extra);
      if (n >= lat + 1) clear_over = 1'b0;
      chk("busy", 32'(busy), 32'(n <= lat));
      chk("finished", 32'(finished), 32'(n == lat));
      if (finished) begin
        fcount++;
        if (obs_lat < 0) obs_lat = n;
      end
      if (n >= 2 && n < lat && (n % 2) == 0) begin
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr[(n-2)/2]));
        obs_addr.push_back(int'(rom_addr));
      end else begin
        chk("rom_addr_idle", 32'(rom_addr), 32'd0);
      end
    end
    start = 1'b0; clear_over = 1'b0;
    chk("finished_pulses", 32'(fcount), 32'd1);
    check_state("step");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; freeze = 1'b0; clear_over = 1'b0;
    ghost_en = '0; player_x = '0; player_y = '0;
    for (int i = 0; i < 512; i++) rom[i] = word($urandom_range(0, 3), $urandom_range(0, 3));
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_state("rst");
    reset = 1'b0;

    rom[1] = word(5, 5); rom[64] = word(13, 5); rom[143] = word(21, 5);
    step(0, 3'b111, 1, 1, 0, 0);
    chk("a_lat", 32'(obs_lat), 32'd8);
    chk("a_addr0", 32'(obs_addr[0]), 32'd1);
    chk("a_addr1", 32'(obs_addr[1]), 32'd64);
    chk("a_addr2", 32'(obs_addr[2]), 32'd143);
    chk("a_ghost_x", 32'(ghost_x), 32'({5'd21, 5'd13, 5'd5}));
    chk("a_hit", 32'(hit_mask), 32'd0);

    rom[2] = word(7, 7); rom[65] = word(5, 5); rom[144] = word(9, 9);
    step(0, 3'b111, 5, 5, 0, 0);
    chk("hit_mask_g1", 32'(hit_mask), 32'b010);
    chk("hit_over", 32'(game_over), 32'd1);

    rom[3] = word(0, 1); rom[66] = word(0, 2); rom[145] = word(0, 3);
    step(0, 3'b111, 10, 10, 0, 0);
    chk("clean_over_sticky", 32'(game_over), 32'd1);
    chk("clean_hit", 32'(hit_mask), 32'd0);

    @(negedge clock); clear_over = 1'b1;
    @(negedge clock); clear_over = 1'b0;
    m_go = 0;
    chk("clear_over", 32'(game_over), 32'd0);

    rom[4] = word(5, 5); rom[67] = word(20, 1); rom[146] = word(20, 2);
    step(0, 3'b111, 4, 5, 0, 0);
    rom[5] = word(4, 5); rom[68] = word(20, 3); rom[147] = word(20, 4);
    step(0, 3'b111, 5, 5, 0, 0);
    chk("swap_hit", 32'(hit_mask), 32'b001);

    while (m_idx[0] != 63) step(0, 3'b001, 31, 15, 0, 0);
    step(0, 3'b001, 31, 15, 0, 0);
    chk("wrap_addr", 32'(obs_addr[0]), 32'd0);

    step(0, 3'b101, 31, 15, 0, 0);
    step(1, 3'b101, 31, 15, 0, 0);
    chk("freeze_lat", 32'(obs_lat), 32'd6);
    chk("freeze_fetches", 32'(obs_addr.size()), 32'd2);
    chk("freeze_g1_x", 32'(ghost_x[9:5]), 32'd20);
    chk("freeze_g1_y", 32'(ghost_y[7:4]), 32'd3);

    step(0, 3'b111, 2, 2, 0, 3);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] en;
      en = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 3) == 0), en, $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0), (en != 0 && $urandom_range(0, 2) == 0) ? 2 : 0);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clock); clear_over = 1'b1;
        @(negedge clock); clear_over = 1'b0;
        m_go = 0;
        chk("rand_clear", 32'(game_over), 32'd0);
      end
    end

    rom[1] = word(3, 3);
    step(0, 3'b111, 3, 3, 0, 0);
    @(negedge clock);
    start = 1'b1; ghost_en = 3'b111; freeze = 1'b0; player_x = 5'd1; player_y = 4'd1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_finished", 32'(finished), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check_state("mid_rst");
    for (int n = 0; n < 10; n++) begin
      @(posedge clock);
      #1;
      chk("mid_rst_no_finish", 32'(finished), 32'd0);
    end
    step(0, 3'b111, 31, 15, 0, 0);
    chk("post_rst_addr0", 32'(obs_addr[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
